// File: rtl/multi_button_debounce.sv
// multi_button_debounce
// Multi-channel button debouncer. Each channel has its own 2-FF synchroniser,
// its own four-state qualification FSM and its own stable counter, and reports
// a clean level plus one-cycle press/release pulses.
// Optional long-press / auto-repeat pulse on hold_o is built only when the
// macro DEBOUNCE_HOLD_EN is defined; otherwise hold_o is tied to 0.
// Debug: state_o carries every channel's FSM state, two bits per channel
// (channel c in bits [2c+1:2c]; 0=IDLE 1=PRESS_CHECK 2=PRESSED 3=RELEASE_CHECK).
// The fall pulse port is named release_o because "release" is a reserved word.
module multi_button_debounce #(
  parameter int CHANNELS      = 4,
  parameter int CLK_FREQUENCY = 10_000_000,
  parameter int DEBOUNCE_HZ   = 200,
  parameter int HOLD_CYCLES   = 5_000_000,
  parameter int REPEAT_CYCLES = 1_000_000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [CHANNELS-1:0]   button_i,
  output logic [CHANNELS-1:0]   level_o,
  output logic [CHANNELS-1:0]   press_o,
  output logic [CHANNELS-1:0]   release_o,
  output logic [CHANNELS-1:0]   hold_o,
  output logic [2*CHANNELS-1:0] state_o
);

  localparam int STABLE_CYCLES = CLK_FREQUENCY / DEBOUNCE_HZ;
  localparam int CW            = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

`ifdef DEBOUNCE_HOLD_EN
  localparam int MAX_HR = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW     = $clog2(MAX_HR + 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_CYCLES - 1);
`else
  // Hold configuration has no effect in this build.
  logic [31:0] unused_hold_cfg;
  assign unused_hold_cfg = HOLD_CYCLES ^ REPEAT_CYCLES;
`endif

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    PRESS_CHECK   = 2'd1,
    PRESSED       = 2'd2,
    RELEASE_CHECK = 2'd3
  } state_t;

  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;

  // Two-flop synchroniser for every raw button pin.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s;
    logic          press_commit;
    logic          release_commit;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    assign s              = sync2_q[c];
    assign press_commit   = (state_q == PRESS_CHECK)   &&  s && (cnt_q == STABLE_LAST);
    assign release_commit = (state_q == RELEASE_CHECK) && !s && (cnt_q == STABLE_LAST);

    // State and stable-counter register.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Next state: a check state commits only after STABLE_CYCLES agreeing samples.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        IDLE: begin
          if (s) begin
            state_d = PRESS_CHECK;
            cnt_d   = '0;
          end
        end
        PRESS_CHECK: begin
          if (!s) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!s) begin
            state_d = RELEASE_CHECK;
            cnt_d   = '0;
          end
        end
        RELEASE_CHECK: begin
          if (s) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Output decode: pulses and level change are taken on the committing edge.
    always_comb begin
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (press_commit) begin
        level_d = 1'b1;
        press_d = 1'b1;
      end
      if (release_commit) begin
        level_d   = 1'b0;
        release_d = 1'b1;
      end
    end

    // Registered level and pulse outputs.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign level_o[c]         = level_q;
    assign press_o[c]         = press_q;
    assign release_o[c]       = release_q;
    assign state_o[2*c +: 2]  = state_q;

`ifdef DEBOUNCE_HOLD_EN
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          rep_q, rep_d;   // first hold pulse already issued
    logic          hold_q, hold_d;

    // Hold counter: first pulse after HOLD_CYCLES, then every REPEAT_CYCLES.
    always_comb begin
      hcnt_d = hcnt_q;
      rep_d  = rep_q;
      hold_d = 1'b0;
      case (state_q)
        PRESSED, RELEASE_CHECK: begin
          if (release_commit) begin
            hcnt_d = '0;
            rep_d  = 1'b0;
          end else if (!rep_q) begin
            if (hcnt_q == HOLD_LAST) begin
              hold_d = 1'b1;
              hcnt_d = '0;
              rep_d  = 1'b1;
            end else begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end else if (REPEAT_CYCLES > 0) begin
            if (hcnt_q == REPEAT_LAST) begin
              hold_d = 1'b1;
              hcnt_d = '0;
            end else begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end
        end
        default: begin
          hcnt_d = '0;
          rep_d  = 1'b0;
        end
      endcase
    end

    // Hold counter and hold pulse register.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        hcnt_q <= '0;
        rep_q  <= 1'b0;
        hold_q <= 1'b0;
      end else begin
        hcnt_q <= hcnt_d;
        rep_q  <= rep_d;
        hold_q <= hold_d;
      end
    end

    assign hold_o[c] = hold_q;
`else
    assign hold_o[c] = 1'b0;
`endif
  end

endmodule
